// File: rtl/traffic_display_scan_if.sv
// Display-stage bus: controller-side inputs and display/LED drive outputs.
interface traffic_display_scan_if;
  logic       EN;
  logic [7:0] ACOUNT;
  logic [7:0] BCOUNT;
  logic [3:0] LAMPA;
  logic [3:0] LAMPB;
  logic [6:0] SEG;
  logic [3:0] DIG;
  logic [3:0] LEDA;
  logic [3:0] LEDB;
  logic       BCD_ERR;

  // Driver side (controller / bench)
  modport master (
    output EN, ACOUNT, BCOUNT, LAMPA, LAMPB,
    input  SEG, DIG, LEDA, LEDB, BCD_ERR
  );

  // Display block side
  modport slave (
    input  EN, ACOUNT, BCOUNT, LAMPA, LAMPB,
    output SEG, DIG, LEDA, LEDB, BCD_ERR
  );
endinterface

// File: rtl/traffic_display_scan.sv
// 4-digit multiplexed 7-segment scanner and lamp LED driver for the
// traffic-light controller, with frame-coherent shadow capture.
module traffic_display_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic                  CLK,
  input logic                  RST,
  traffic_display_scan_if.slave bus
);

  localparam int unsigned PC_W = $clog2(SCAN_DIV);
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_OFF   = 7'b0000000;
  localparam logic [3:0] DIG_OFF   = 4'b1111;
  localparam logic [3:0] LAMP_LEFT = 4'b0001;
  localparam logic [3:0] LAMP_GRN  = 4'b0010;
  localparam logic [3:0] LAMP_YEL  = 4'b0100;
  localparam logic [3:0] LAMP_RED  = 4'b1000;
  localparam logic [3:0] LED_OFF   = 4'b0000;

  // Scan / blink state
  logic [PC_W-1:0] pc, pc_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
  logic            phase, phase_nxt;

  // Frame-coherent shadows
  logic [7:0] sh_acount, sh_acount_nxt;
  logic [7:0] sh_bcount, sh_bcount_nxt;
  logic [3:0] sh_lampa, sh_lampa_nxt;
  logic [3:0] sh_lampb, sh_lampb_nxt;

  // Registered outputs
  logic [6:0] seg_q, seg_nxt;
  logic [3:0] dig_q, dig_nxt;
  logic [3:0] leda_q, leda_nxt;
  logic [3:0] ledb_q, ledb_nxt;
  logic       err_q, err_nxt;

  // Decode helpers
  logic       slot_tick_c;
  logic       frame_tick_c;
  logic       load_c;
  logic [3:0] nib_c;
  logic       nib_bad_c;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Legal single lamps pass through, yellow blinks, anything else forces red
  function automatic logic [3:0] led_map(input logic [3:0] code, input logic ph);
    logic [3:0] l;
    case (code)
      LAMP_LEFT, LAMP_GRN, LAMP_RED: l = code;
      LAMP_YEL:                      l = ph ? LAMP_YEL : LED_OFF;
      default:                       l = LAMP_RED;
    endcase
    return l;
  endfunction

  // Next-state and next-output computation from the current state
  always_comb begin
    pc_nxt        = pc;
    idx_nxt       = idx;
    frame_cnt_nxt = frame_cnt;
    phase_nxt     = phase;
    sh_acount_nxt = sh_acount;
    sh_bcount_nxt = sh_bcount;
    sh_lampa_nxt  = sh_lampa;
    sh_lampb_nxt  = sh_lampb;
    seg_nxt       = SEG_OFF;
    dig_nxt       = DIG_OFF;
    err_nxt       = err_q;

    slot_tick_c  = (pc == PC_W'(SCAN_DIV - 1));
    frame_tick_c = slot_tick_c && (idx == 2'd3);
    load_c       = (idx == 2'd0) && (pc == '0);

    pc_nxt = slot_tick_c ? '0 : pc + PC_W'(1);
    if (slot_tick_c) begin
      idx_nxt = idx + 2'd1;
    end

    // Blink half-period counted in whole frames, toggled at the 3->0 tick
    if (frame_tick_c) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_nxt = '0;
        phase_nxt     = ~phase;
      end else begin
        frame_cnt_nxt = frame_cnt + FC_W'(1);
      end
    end

    if (load_c) begin
      sh_acount_nxt = bus.ACOUNT;
      sh_bcount_nxt = bus.BCOUNT;
      sh_lampa_nxt  = bus.LAMPA;
      sh_lampb_nxt  = bus.LAMPB;
    end

    case (idx)
      2'd0:    nib_c = sh_acount[7:4];
      2'd1:    nib_c = sh_acount[3:0];
      2'd2:    nib_c = sh_bcount[7:4];
      default: nib_c = sh_bcount[3:0];
    endcase
    nib_bad_c = (nib_c > 4'd9);

    if (!bus.EN || nib_bad_c) begin
      seg_nxt = SEG_DASH;
    end else if (!idx[0] && (nib_c == 4'd0)) begin
      seg_nxt = SEG_OFF;
    end else begin
      seg_nxt = seg7(nib_c);
    end

    if (!bus.EN) begin
      err_nxt = 1'b0;
    end else if (nib_bad_c) begin
      err_nxt = 1'b1;
    end

    if (pc >= PC_W'(BLANK)) begin
      dig_nxt = ~(4'b0001 << idx);
    end

    leda_nxt = led_map(sh_lampa, phase);
    ledb_nxt = led_map(sh_lampb, phase);
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc        <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b1;
      sh_acount <= '0;
      sh_bcount <= '0;
      sh_lampa  <= LAMP_RED;
      sh_lampb  <= LAMP_RED;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
      leda_q    <= LAMP_RED;
      ledb_q    <= LAMP_RED;
      err_q     <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      idx       <= idx_nxt;
      frame_cnt <= frame_cnt_nxt;
      phase     <= phase_nxt;
      sh_acount <= sh_acount_nxt;
      sh_bcount <= sh_bcount_nxt;
      sh_lampa  <= sh_lampa_nxt;
      sh_lampb  <= sh_lampb_nxt;
      seg_q     <= seg_nxt;
      dig_q     <= dig_nxt;
      leda_q    <= leda_nxt;
      ledb_q    <= ledb_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.SEG     = seg_q;
  assign bus.DIG     = dig_q;
  assign bus.LEDA    = leda_q;
  assign bus.LEDB    = ledb_q;
  assign bus.BCD_ERR = err_q;

endmodule

// File: tb/tb_traffic_display_scan.sv
// Self-checking bench for traffic_display_scan: cycle-level reference model
// built from absolute cycle arithmetic, constant vector table, corner sequences
// and randomized stimulus.
module tb_traffic_display_scan;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;
  localparam int MAXC  = 4096;

  logic CLK = 1'b0;
  logic RST;

  traffic_display_scan_if bus();

  traffic_display_scan #(
    .SCAN_DIV(SD), .BLANK(BL), .BLINK_FRAMES(BF)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Input history since the last reset release, indexed by cycle number
  logic [7:0] h_a  [MAXC];
  logic [7:0] h_b  [MAXC];
  logic [3:0] h_la [MAXC];
  logic [3:0] h_lb [MAXC];
  logic       m_err;

  logic [6:0] seg_tab [10];

  typedef struct {
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] la;
    logic [3:0] lb;
    logic [6:0] s0, s1, s2, s3;
    logic [3:0] leda;
    logic [3:0] ledb;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
  endtask

  function automatic logic [6:0] m_seg(input logic en, input logic [3:0] nib, input bit tens);
    if (!en || nib > 4'd9) return 7'b1000000;
    if (tens && nib == 4'd0) return 7'b0000000;
    return seg_tab[nib];
  endfunction

  function automatic logic [3:0] m_led(input logic [3:0] code, input logic ph);
    if (code == 4'd1 || code == 4'd2 || code == 4'd8) return code;
    if (code == 4'd4) return ph ? 4'b0100 : 4'b0000;
    return 4'b1000;
  endfunction

  // One clock: record inputs, predict outputs from cycle arithmetic, compare
  task automatic step();
    int pc, idx, cap;
    logic [7:0] sa, sb;
    logic [3:0] sla, slb, nib, dg;
    logic ph;
    logic [19:0] exp;
    if (cyc >= MAXC) begin
      $display("FAIL history: cycle budget exhausted");
      $fatal(1);
    end
    h_a[cyc]  = bus.ACOUNT;
    h_b[cyc]  = bus.BCOUNT;
    h_la[cyc] = bus.LAMPA;
    h_lb[cyc] = bus.LAMPB;
    pc  = cyc % SD;
    idx = (cyc / SD) % 4;
    if (cyc == 0) begin
      sa = 8'h00; sb = 8'h00; sla = 4'b1000; slb = 4'b1000;
    end else begin
      cap = FRAME * ((cyc - 1) / FRAME);
      sa = h_a[cap]; sb = h_b[cap]; sla = h_la[cap]; slb = h_lb[cap];
    end
    ph = ((cyc / (FRAME * BF)) % 2) == 0;
    case (idx)
      0:       nib = sa[7:4];
      1:       nib = sa[3:0];
      2:       nib = sb[7:4];
      default: nib = sb[3:0];
    endcase
    if (!bus.EN) m_err = 1'b0;
    else if (nib > 4'd9) m_err = 1'b1;
    dg = (pc < BL) ? 4'b1111 : ~(4'b0001 << idx);
    exp = {m_seg(bus.EN, nib, (idx % 2) == 0), dg, m_led(sla, ph), m_led(slb, ph), m_err};
    @(posedge CLK);
    #1;
    check("cycle", 32'({bus.SEG, bus.DIG, bus.LEDA, bus.LEDB, bus.BCD_ERR}), 32'(exp));
    cyc++;
    @(negedge CLK);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic to_frame_pos(input int p);
    for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) step();
  endtask

  // Run until the given digit is lit and return its segments (x on timeout)
  task automatic seg_on_digit(input logic [3:0] d, output logic [6:0] s);
    s = 'x;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (bus.DIG == d) begin
        s = bus.SEG;
        break;
      end
    end
  endtask

  // Mid-scan asynchronous reset, then release on a falling edge
  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    check("reset_async", 32'({bus.SEG, bus.DIG, bus.LEDA, bus.LEDB, bus.BCD_ERR}),
          32'({7'b0000000, 4'b1111, 4'b1000, 4'b1000, 1'b0}));
    @(negedge CLK);
    @(negedge CLK);
    check("reset_hold", 32'({bus.SEG, bus.DIG, bus.LEDA, bus.LEDB, bus.BCD_ERR}),
          32'({7'b0000000, 4'b1111, 4'b1000, 4'b1000, 1'b0}));
    RST   = 1'b0;
    cyc   = 0;
    m_err = 1'b0;
  endtask

  task automatic set_in(input logic en, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] la, input logic [3:0] lb);
    bus.EN = en; bus.ACOUNT = a; bus.BCOUNT = b; bus.LAMPA = la; bus.LAMPB = lb;
  endtask

  function automatic logic [7:0] rnd_count();
    if ($urandom_range(0, 9) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  function automatic logic [3:0] rnd_lamp();
    case ($urandom_range(0, 5))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd4;
      3: return 4'd8;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    logic [6:0] seen [4];
    logic [6:0] s;
    logic [3:0] v0;
    int len;

    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    tbl[0] = '{1'b1, 8'h37, 8'h05, 4'd2, 4'd8, 7'b1001111, 7'b0000111, 7'b0000000, 7'b1101101, 4'b0010, 4'b1000};
    tbl[1] = '{1'b1, 8'h00, 8'h99, 4'd1, 4'd2, 7'b0000000, 7'b0111111, 7'b1101111, 7'b1101111, 4'b0001, 4'b0010};
    tbl[2] = '{1'b1, 8'h3A, 8'hF0, 4'd8, 4'd0, 7'b1001111, 7'b1000000, 7'b1000000, 7'b0111111, 4'b1000, 4'b1000};
    tbl[3] = '{1'b0, 8'h12, 8'h48, 4'd3, 4'd6, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1000, 4'b1000};
    tbl[4] = '{1'b1, 8'h56, 8'h80, 4'd2, 4'd1, 7'b1101101, 7'b1111101, 7'b1111111, 7'b0111111, 4'b0010, 4'b0001};

    RST   = 1'b1;
    m_err = 1'b0;
    set_in(1'b1, 8'h37, 8'h05, 4'd2, 4'd8);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;

    // Normal display slot pattern, then a mid-scan reset
    steps(2 * FRAME + 6);
    do_reset();
    steps(FRAME);

    // Constant vector table: last of two frames must show the row's digits
    for (int r = 0; r < 5; r++) begin
      set_in(tbl[r].en, tbl[r].a, tbl[r].b, tbl[r].la, tbl[r].lb);
      for (int k = 0; k < 4; k++) seen[k] = 'x;
      for (int i = 0; i < 2 * FRAME; i++) begin
        step();
        if (i >= FRAME) begin
          case (bus.DIG)
            4'b1110: seen[0] = bus.SEG;
            4'b1101: seen[1] = bus.SEG;
            4'b1011: seen[2] = bus.SEG;
            4'b0111: seen[3] = bus.SEG;
            default: ;
          endcase
        end
      end
      check($sformatf("tbl%0d_d0", r), 32'(seen[0]), 32'(tbl[r].s0));
      check($sformatf("tbl%0d_d1", r), 32'(seen[1]), 32'(tbl[r].s1));
      check($sformatf("tbl%0d_d2", r), 32'(seen[2]), 32'(tbl[r].s2));
      check($sformatf("tbl%0d_d3", r), 32'(seen[3]), 32'(tbl[r].s3));
      check($sformatf("tbl%0d_leda", r), 32'(bus.LEDA), 32'(tbl[r].leda));
      check($sformatf("tbl%0d_ledb", r), 32'(bus.LEDB), 32'(tbl[r].ledb));
    end

    // Frame coherence: change during idx=1 shows next frame only
    set_in(1'b1, 8'h37, 8'h05, 4'd2, 4'd8);
    steps(2 * FRAME);
    to_frame_pos(5);
    bus.ACOUNT = 8'h36;
    seg_on_digit(4'b1101, s);
    check("coherent_old", 32'(s), 32'(7'b0000111));
    to_frame_pos(0);
    seg_on_digit(4'b1101, s);
    check("coherent_new", 32'(s), 32'(7'b1111101));

    // Invalid BCD: dash + sticky error, cleared only by EN=0
    to_frame_pos(0);
    bus.ACOUNT = 8'h3A;
    step();
    seg_on_digit(4'b1101, s);
    check("bad_dash", 32'(s), 32'(7'b1000000));
    check("bad_err", 32'(bus.BCD_ERR), 32'(1));
    bus.ACOUNT = 8'h37;
    steps(2 * FRAME);
    check("err_sticky", 32'(bus.BCD_ERR), 32'(1));
    bus.EN = 1'b0;
    step();
    check("err_clear", 32'(bus.BCD_ERR), 32'(0));
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (bus.DIG != 4'b1111) check("en0_dash", 32'(bus.SEG), 32'(7'b1000000));
    end
    bus.EN = 1'b1;
    steps(2 * FRAME);
    check("err_after_en", 32'(bus.BCD_ERR), 32'(0));

    // Yellow blink: 32-cycle half-periods aligned to frame starts
    bus.LAMPA = 4'd4;
    steps(2 * FRAME);
    v0 = bus.LEDA;
    len = 0;
    while (bus.LEDA == v0 && len < 80) begin step(); len++; end
    for (int h = 0; h < 2; h++) begin
      v0 = bus.LEDA;
      check("blink_align", 32'(cyc % FRAME), 32'(1));
      len = 0;
      while (bus.LEDA == v0 && len < 80) begin step(); len++; end
      check("blink_len", 32'(len), 32'(FRAME * BF));
      check("blink_alt", 32'(bus.LEDA), 32'(v0 ^ 4'b0100));
    end

    // Fail-safe red for illegal lamp codes
    bus.LAMPB = 4'd2;
    steps(2 * FRAME);
    check("ledb_green", 32'(bus.LEDB), 32'(4'b0010));
    bus.LAMPB = 4'b0110;
    steps(2 * FRAME);
    check("ledb_multi", 32'(bus.LEDB), 32'(4'b1000));
    bus.LAMPB = 4'd2;
    steps(2 * FRAME);
    bus.LAMPB = 4'b0000;
    steps(2 * FRAME);
    check("ledb_zero", 32'(bus.LEDB), 32'(4'b1000));

    // Randomized stimulus against the model, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bus.ACOUNT = rnd_count();
      if ($urandom_range(0, 7) == 0) bus.BCOUNT = rnd_count();
      if ($urandom_range(0, 11) == 0) bus.LAMPA = rnd_lamp();
      if ($urandom_range(0, 11) == 0) bus.LAMPB = rnd_lamp();
      if ($urandom_range(0, 15) == 0) bus.EN = ~bus.EN;
      if (i == 200) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
